// File: rtl/sync_reset_seq.sv
// rtl/sync_reset_seq.sv - pad reset synchronizer and ordered per-channel reset release sequencer
// Channels release one at a time after a hold period; software requests restart the hold phase.
module sync_reset_seq #(
   parameter int NCH      = 3,
   parameter int N_SYNC   = 2,
   parameter int HOLD_CYC = 4,
   parameter int GAP_CYC  = 3
) (
   input  logic           clk,
   input  logic           ext_rst_n,
   input  logic           test_en,
   input  logic           sw_rst_req,
   output logic [NCH-1:0] rst_n,
   output logic           rst_done
);

   localparam int MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam int IDX_W   = (NCH > 1) ? $clog2(NCH) : 1;

   if (NCH < 1 || N_SYNC < 2 || HOLD_CYC < 1 || GAP_CYC < 1) begin : g_param_check
      $error("sync_reset_seq: illegal parameter value");
   end

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_HOLD,
      ST_RELEASE,
      ST_DONE
   } state_e;

   logic [N_SYNC-1:0] sync_q;
   logic              sync_n;
   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [NCH-1:0]    rst_n_q, rst_n_d;
   logic              done_q, done_d;
   logic              hold_last;

   always_ff @(posedge clk or negedge ext_rst_n) begin
      if (!ext_rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[N_SYNC-2:0], 1'b1};
      end
   end

   assign sync_n = sync_q[N_SYNC-1];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      rst_n_d   = rst_n_q;
      done_d    = done_q;
      hold_last = 1'b0;

      // The edge that observes sync_n already counts as the first hold cycle.
      case (state_q)
         ST_SYNC: begin
            if (sync_n) begin
               if (HOLD_CYC == 1) begin
                  hold_last = 1'b1;
               end else begin
                  state_d = ST_HOLD;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         ST_HOLD: begin
            if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
               hold_last = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RELEASE: begin
            if (cnt_q == CNT_W'(GAP_CYC - 1)) begin
               rst_n_d = rst_n_q | (NCH'(1) << idx_q);
               cnt_d   = '0;
               if (idx_q == IDX_W'(NCH - 1)) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
         end
         default: state_d = ST_SYNC;
      endcase

      // Channel 0 leaves reset on the final hold edge; RELEASE then paces the rest.
      if (hold_last) begin
         rst_n_d = rst_n_q | NCH'(1);
         cnt_d   = '0;
         if (NCH == 1) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
         end else begin
            state_d = ST_RELEASE;
            idx_d   = IDX_W'(1);
         end
      end

      if (sw_rst_req && state_q != ST_SYNC) begin
         state_d = ST_HOLD;
         cnt_d   = '0;
         idx_d   = '0;
         rst_n_d = '0;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge ext_rst_n) begin
      if (!ext_rst_n) begin
         state_q <= ST_SYNC;
         cnt_q   <= '0;
         idx_q   <= '0;
         rst_n_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rst_n_q <= rst_n_d;
         done_q  <= done_d;
      end
   end

   assign rst_n    = test_en ? {NCH{ext_rst_n}} : rst_n_q;
   assign rst_done = test_en ? ext_rst_n : done_q;

endmodule
